// File: rtl/cdb_writeback_arbiter.sv
// rtl/cdb_writeback_arbiter.sv - reservation-station busy tracking and round-robin CDB writeback arbiter
// Station tags: Add0..Add2 = 1..3, MUL0..MUL2 = 4..6, Mem0 = 7, Mem1 = 8; any other code is unrecognised.
module cdb_writeback_arbiter (
  input  logic         CLK,
  input  logic         RST,
  input  logic         issue_valid,
  input  logic [4:0]   issue_stnum,
  input  logic [7:0]   done_req,
  input  logic [255:0] done_val,
  output logic [7:0]   done_ack,
  output logic         cdb_valid,
  output logic [4:0]   cdb_tag,
  output logic [31:0]  cdb_data,
  output logic [2:0]   Add_Busy,
  output logic [2:0]   Mul_Busy,
  output logic [1:0]   Mem_Busy
);

  logic [7:0] busy;
  logic [2:0] rr_ptr;
  logic [7:0] eligible;
  logic [3:0] cand;
  logic       grant_valid;
  logic [2:0] grant_idx;
  logic       store_ack;
  logic       issue_known;
  logic [2:0] issue_idx;
  logic       issue_take;

  assign Add_Busy = busy[2:0];
  assign Mul_Busy = busy[5:3];
  assign Mem_Busy = busy[7:6];

  // Mem1 is a store: it never writes the CDB, so it is excluded from arbitration.
  assign eligible  = RST ? 8'd0 : {1'b0, done_req[6:0] & busy[6:0]};
  assign store_ack = !RST && done_req[7] && busy[7];

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = 3'd0;
    cand        = 4'd0;
    // Walk offsets from farthest to nearest so the nearest eligible station wins.
    for (int k = 6; k >= 0; k--) begin
      cand = {1'b0, rr_ptr} + 4'(k);
      if (cand >= 4'd7) cand = cand - 4'd7;
      if (eligible[cand[2:0]]) begin
        grant_valid = 1'b1;
        grant_idx   = cand[2:0];
      end
    end
  end

  always_comb begin
    done_ack = 8'd0;
    if (grant_valid) done_ack[grant_idx] = 1'b1;
    if (store_ack)   done_ack[7] = 1'b1;
  end

  // Busy is sampled before this edge's frees, so an issue to a station being freed is dropped.
  assign issue_known = (issue_stnum != 5'd0) && (issue_stnum <= 5'd8);
  assign issue_idx   = issue_stnum[2:0] - 3'd1;
  assign issue_take  = !RST && issue_valid && issue_known && !busy[issue_idx];

  always_ff @(posedge CLK) begin
    if (RST) begin
      busy      <= 8'd0;
      rr_ptr    <= 3'd0;
      cdb_valid <= 1'b0;
      cdb_tag   <= 5'd0;
      cdb_data  <= 32'd0;
    end else begin
      cdb_valid <= grant_valid;
      if (grant_valid) begin
        cdb_tag         <= {2'b00, grant_idx} + 5'd1;
        cdb_data        <= done_val[{grant_idx, 5'b00000} +: 32];
        busy[grant_idx] <= 1'b0;
        rr_ptr          <= (grant_idx == 3'd6) ? 3'd0 : grant_idx + 3'd1;
      end
      if (store_ack) busy[7] <= 1'b0;
      if (issue_take) busy[issue_idx] <= 1'b1;
    end
  end

endmodule
